// File: rtl/map_port_arbiter.sv
// Single-port arbiter for the 13x13 map-tile memory: renderer on port 0, starvation-protected
// round-robin for the others, row*13+col addressing and tagged read-return routing.
// Optional per-port stall statistics when ARB_STATS_EN is defined.
module map_port_arbiter #(
  parameter int         NUM_REQ     = 4,
  parameter int         RD_LAT      = 1,
  parameter int         MAX_WAIT    = 8,
  parameter logic [7:0] BORDER_TILE = 8'd15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_row,
  input  logic [4*NUM_REQ-1:0]   req_col,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
`ifdef ARB_STATS_EN
  input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
  output logic [15:0]            stat_val,
`endif
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rvalid,
  output logic [7:0]             rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [7:0]             mem_addr,
  output logic [7:0]             mem_din,
  input  logic [7:0]             mem_dout
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic             vld;
    logic             oog;
    logic [IDX_W-1:0] port;
  } tag_t;

  logic [IDX_W-1:0]   rr_ptr;
  logic [WAIT_W-1:0]  wait_cnt [1:NUM_REQ-1];
  tag_t               iss_q;
  tag_t               tag_q [RD_LAT];

  logic               any_gnt;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W:0]     rr_cand;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [3:0]         g_row;
  logic [3:0]         g_col;
  logic               g_we;
  logic [7:0]         g_wdata;
  logic               g_oog;
  logic [7:0]         g_addr;

  // Grant decision: starved ports first (lowest index), then the renderer, then round-robin.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no latch can be inferred.
    any_gnt = 1'b0;
    sel     = '0;
    rr_cand = '0;
    for (int i = NUM_REQ - 1; i >= 1; i--) begin
      if (req[i] && wait_cnt[i] == WAIT_W'(MAX_WAIT)) begin
        any_gnt = 1'b1;
        sel     = IDX_W'(i);
      end
    end
    if (!any_gnt && req[0]) begin
      any_gnt = 1'b1;
      sel     = '0;
    end
    if (!any_gnt) begin
      // Walk backwards so the candidate closest to the pointer is the last one written.
      for (int j = NUM_REQ - 2; j >= 0; j--) begin
        rr_cand = {1'b0, rr_ptr} + (IDX_W+1)'(j);
        if (rr_cand >= (IDX_W+1)'(NUM_REQ)) rr_cand = rr_cand - (IDX_W+1)'(NUM_REQ - 1);
        if (req[rr_cand[IDX_W-1:0]]) begin
          any_gnt = 1'b1;
          sel     = rr_cand[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt_nxt = any_gnt ? (NUM_REQ'(1) << sel) : '0;
    g_row   = req_row[{sel, 2'b00} +: 4];
    g_col   = req_col[{sel, 2'b00} +: 4];
    g_we    = req_we[sel];
    g_wdata = req_wdata[{sel, 3'b000} +: 8];
    g_oog   = (g_row > 4'd12) || (g_col > 4'd12);
    g_addr  = 8'(g_row) * 8'd13 + 8'(g_col);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rr_ptr   <= IDX_W'(1);
      iss_q    <= '0;
      for (int i = 1; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
      gnt    <= gnt_nxt;
      mem_en <= any_gnt && !g_oog;
      mem_we <= any_gnt && !g_oog && g_we;
      if (any_gnt) begin
        mem_addr <= g_addr;
        mem_din  <= g_wdata;
      end
      if (any_gnt && sel != '0)
        rr_ptr <= (sel == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : sel + IDX_W'(1);
      for (int i = 1; i < NUM_REQ; i++) begin
        if (gnt_nxt[i] || !req[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != WAIT_W'(MAX_WAIT))
          wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
      end
      iss_q.vld  <= any_gnt && !g_we;
      iss_q.oog  <= g_oog;
      iss_q.port <= sel;
    end
  end

  // Return path: the issue register plus RD_LAT tag stages line up with mem_dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= '0;
      rdata  <= '0;
      for (int s = 0; s < RD_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= iss_q;
      for (int s = 1; s < RD_LAT; s++) tag_q[s] <= tag_q[s-1];
      rvalid <= tag_q[RD_LAT-1].vld ? (NUM_REQ'(1) << tag_q[RD_LAT-1].port) : '0;
      if (tag_q[RD_LAT-1].vld)
        rdata <= tag_q[RD_LAT-1].oog ? BORDER_TILE : mem_dout;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_val <= '0;
      for (int i = 0; i < NUM_REQ; i++) stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && !gnt_nxt[i] && stall_cnt[i] != 16'hFFFF)
          stall_cnt[i] <= stall_cnt[i] + 16'd1;
      end
      stat_val <= stall_cnt[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_map_port_arbiter.sv
// Self-checking bench for map_port_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model and a behavioural write-first map RAM.
module tb_map_port_arbiter;

  localparam int         NUM_REQ  = 4;
  localparam int         RD_LAT   = 1;
  localparam int         MAX_WAIT = 8;
  localparam logic [7:0] BORDER   = 8'd15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] req_row;
  logic [4*NUM_REQ-1:0] req_col;
  logic [NUM_REQ-1:0]   req_we;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   rvalid;
  logic [7:0]           rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [7:0]           mem_addr;
  logic [7:0]           mem_din;
  logic [7:0]           mem_dout;
`ifdef ARB_STATS_EN
  logic [1:0]           stat_sel;
  logic [15:0]          stat_val;
`endif

  map_port_arbiter #(
    .NUM_REQ(NUM_REQ), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT), .BORDER_TILE(BORDER)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_row(req_row), .req_col(req_col),
    .req_we(req_we), .req_wdata(req_wdata),
`ifdef ARB_STATS_EN
    .stat_sel(stat_sel), .stat_val(stat_val),
`endif
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(int a);
    if (a == 78) return 8'd11;
    return 8'((a * 37 + 5) & 255);
  endfunction

  // Behavioural map RAM, write-first, RD_LAT cycles of read latency.
  logic       ram_init = 1'b0;
  logic [7:0] ram [256];
  logic [7:0] dpipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int a = 0; a < 256; a++) ram[a] <= init_val(a);
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_din;
    end
    if (mem_en) dpipe[0] <= mem_we ? mem_din : ram[mem_addr];
    for (int s = 1; s < RD_LAT; s++) dpipe[s] <= dpipe[s-1];
  end
  assign mem_dout = dpipe[RD_LAT-1];

  // Reference model state.
  typedef struct { int due; int port; logic [7:0] data; } rd_t;
  rd_t                rq[$];
  logic [7:0]         shadow [256];
  int                 m_wait [NUM_REQ];
  int                 m_ptr;
  int                 cyc;
  logic [NUM_REQ-1:0] e_gnt, e_rvalid;
  logic               e_en, e_we;
  logic [7:0]         e_addr, e_din, e_rdata;
  int                 total = 0;
  int                 bad = 0;

  function automatic int pick();
    int k = -1;
    for (int i = 1; i < NUM_REQ; i++)
      if (k < 0 && req[i] && m_wait[i] >= MAX_WAIT) k = i;
    if (k < 0 && req[0]) k = 0;
    for (int j = 0; j < NUM_REQ - 1; j++) begin
      int p = (m_ptr - 1 + j) % (NUM_REQ - 1) + 1;
      if (k < 0 && req[p]) k = p;
    end
    return k;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_REQ; i++) m_wait[i] = 0;
    m_ptr = 1;
    rq.delete();
    e_gnt = '0; e_rvalid = '0; e_en = 1'b0; e_we = 1'b0; e_rdata = 8'd0;
  endtask

  // Advance one clock, predicting what the DUT registers at this edge.
  task automatic tick();
    int k, row, col, a;
    rd_t r;
    k = pick();
    e_gnt = '0; e_en = 1'b0; e_we = 1'b0;
    if (k >= 0) begin
      e_gnt[k] = 1'b1;
      row = int'(req_row[4*k +: 4]);
      col = int'(req_col[4*k +: 4]);
      a = row * 13 + col;
      if (row <= 12 && col <= 12) begin
        e_en = 1'b1;
        e_we = req_we[k];
        e_addr = 8'(a);
        e_din = req_wdata[8*k +: 8];
        if (req_we[k]) shadow[a] = e_din;
      end
      if (!req_we[k]) begin
        r.due = cyc + RD_LAT + 2;
        r.port = k;
        r.data = (row <= 12 && col <= 12) ? shadow[a] : BORDER;
        rq.push_back(r);
      end
    end
    for (int i = 1; i < NUM_REQ; i++)
      m_wait[i] = (req[i] && k != i) ? ((m_wait[i] < MAX_WAIT) ? m_wait[i] + 1 : MAX_WAIT) : 0;
    if (k >= 1) m_ptr = (k == NUM_REQ - 1) ? 1 : k + 1;
    @(posedge clk); #1;
    cyc++;
    e_rvalid = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rvalid[rq[0].port] = 1'b1;
      e_rdata = rq[0].data;
      void'(rq.pop_front());
    end
  endtask

  task automatic set_req(int i, int row, int col, logic we, logic [7:0] wd);
    req[i] = 1'b1;
    req_row[4*i +: 4] = 4'(row);
    req_col[4*i +: 4] = 4'(col);
    req_we[i] = we;
    req_wdata[8*i +: 8] = wd;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    req = '0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL reset_rvalid: got %b want 0000", rvalid); end
    total++; if (rdata !== 8'd0) begin bad++; $display("FAIL reset_rdata: got %0d want 0", rdata); end
    total++; if ({mem_en, mem_we} !== 2'b00) begin bad++; $display("FAIL reset_mem_en_we: got %b want 00", {mem_en, mem_we}); end
    total++; if (mem_addr !== 8'd0) begin bad++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
    total++; if (mem_din !== 8'd0) begin bad++; $display("FAIL reset_mem_din: got %0d want 0", mem_din); end
  endtask

  task automatic test_stats();
`ifdef ARB_STATS_EN
    for (int p = 0; p < NUM_REQ; p++) begin
      stat_sel = 2'(p);
      tick();
      total++; if (stat_val !== 16'd0) begin bad++; $display("FAIL stat_after_reset port %0d: got %0d want 0", p, stat_val); end
    end
`endif
  endtask

  task automatic test_single_read();
    set_req(1, 6, 0, 1'b0, 8'd0);
    tick();
    req[1] = 1'b0;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL single_gnt: got %b want 0010", gnt); end
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL single_en_we: got %b%b want 10", mem_en, mem_we); end
    total++; if (mem_addr !== 8'd78) begin bad++; $display("FAIL single_addr: got %0d want 78", mem_addr); end
    for (int c = 0; c < RD_LAT; c++) begin
      tick();
      total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL single_early_rvalid: got %b want 0000", rvalid); end
    end
    tick();
    total++; if (rvalid !== 4'b0010) begin bad++; $display("FAIL single_rvalid: got %b want 0010", rvalid); end
    total++; if (rdata !== 8'd11) begin bad++; $display("FAIL single_rdata: got %0d want 11", rdata); end
    tick();
    total++; if (rvalid !== 4'b0000 || rdata !== 8'd11) begin bad++; $display("FAIL single_hold: got rvalid %b rdata %0d want 0000 11", rvalid, rdata); end
  endtask

  task automatic test_render_priority();
    do_reset(2);
    set_req(0, 1, 1, 1'b0, 8'd0);
    set_req(2, 2, 2, 1'b0, 8'd0);
    for (int c = 0; c < MAX_WAIT; c++) begin
      tick();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL render_gnt0 cycle %0d: got %b want 0001", c, gnt); end
    end
    tick();
    req[2] = 1'b0;
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL render_starve_gnt2: got %b want 0100", gnt); end
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL render_resume: got %b want 0001", gnt); end
    req = '0;
    repeat (RD_LAT + 3) tick();
  endtask

  task automatic test_round_robin();
    int rr_exp [4] = '{1, 2, 3, 1};
    do_reset(2);
    for (int i = 1; i < NUM_REQ; i++) set_req(i, i, i, 1'b0, 8'd0);
    for (int n = 0; n < 4; n++) begin
      tick();
      total++; if (gnt !== (4'b0001 << rr_exp[n])) begin bad++; $display("FAIL rr_order step %0d: got %b want port %0d", n, gnt, rr_exp[n]); end
    end
    req = '0;
    repeat (RD_LAT + 3) tick();
  endtask

  task automatic test_out_of_grid();
    set_req(3, 13, 4, 1'b0, 8'd0);
    tick();
    req[3] = 1'b0;
    total++; if (gnt !== 4'b1000 || mem_en !== 1'b0) begin bad++; $display("FAIL oog_read_issue: got gnt %b en %b want 1000 0", gnt, mem_en); end
    repeat (RD_LAT) tick();
    tick();
    total++; if (rvalid !== 4'b1000 || rdata !== BORDER) begin bad++; $display("FAIL oog_read_return: got %b %0d want 1000 15", rvalid, rdata); end
    set_req(3, 2, 13, 1'b1, 8'hAA);
    tick();
    req[3] = 1'b0;
    total++; if (gnt !== 4'b1000 || mem_en !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL oog_write_issue: got gnt %b en %b we %b want 1000 0 0", gnt, mem_en, mem_we); end
    for (int c = 0; c < RD_LAT + 2; c++) begin
      tick();
      total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL oog_write_rvalid: got %b want 0000", rvalid); end
    end
    set_req(1, 3, 0, 1'b0, 8'd0);
    tick();
    req[1] = 1'b0;
    repeat (RD_LAT) tick();
    tick();
    total++; if (rvalid !== 4'b0010 || rdata !== init_val(39)) begin bad++; $display("FAIL oog_write_dropped: got %b %0d want 0010 %0d", rvalid, rdata, init_val(39)); end
  endtask

  task automatic test_write_then_read();
    set_req(3, 5, 5, 1'b1, 8'd0);
    tick();
    req[3] = 1'b0;
    total++; if (gnt !== 4'b1000 || {mem_en, mem_we} !== 2'b11) begin bad++; $display("FAIL wr_issue: got gnt %b en/we %b want 1000 11", gnt, {mem_en, mem_we}); end
    total++; if (mem_addr !== 8'd70 || mem_din !== 8'd0) begin bad++; $display("FAIL wr_addr_data: got %0d %0d want 70 0", mem_addr, mem_din); end
    set_req(1, 5, 5, 1'b0, 8'd0);
    tick();
    req[1] = 1'b0;
    total++; if (gnt !== 4'b0010 || mem_addr !== 8'd70 || mem_we !== 1'b0) begin bad++; $display("FAIL rd_issue: got gnt %b addr %0d we %b want 0010 70 0", gnt, mem_addr, mem_we); end
    repeat (RD_LAT) tick();
    tick();
    total++; if (rvalid !== 4'b0010 || rdata !== 8'd0) begin bad++; $display("FAIL wr_rd_return: got %b %0d want 0010 0", rvalid, rdata); end
  endtask

  task automatic test_reset_mid_read();
    set_req(1, 6, 0, 1'b0, 8'd0);
    tick();
    req[1] = 1'b0;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL midrst_gnt: got %b want 0010", gnt); end
    do_reset(1);
    test_reset();
    for (int c = 0; c < RD_LAT + 3; c++) begin
      tick();
      total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL midrst_rvalid cycle %0d: got %b want 0000", c, rvalid); end
    end
    test_stats();
  endtask

  task automatic new_req(int i);
    set_req(i, $urandom_range(0, 13), $urandom_range(0, 13),
            (i != 0) && ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)));
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      tick();
      total++; if (gnt !== e_gnt) begin bad++; $display("FAIL rand_gnt cyc %0d: got %b want %b", cyc, gnt, e_gnt); end
      total++; if ({mem_en, mem_we} !== {e_en, e_we}) begin bad++; $display("FAIL rand_en_we cyc %0d: got %b want %b", cyc, {mem_en, mem_we}, {e_en, e_we}); end
      if (e_en) begin
        total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL rand_addr cyc %0d: got %0d want %0d", cyc, mem_addr, e_addr); end
      end
      if (e_we) begin
        total++; if (mem_din !== e_din) begin bad++; $display("FAIL rand_din cyc %0d: got %0d want %0d", cyc, mem_din, e_din); end
      end
      total++; if (rvalid !== e_rvalid) begin bad++; $display("FAIL rand_rvalid cyc %0d: got %b want %b", cyc, rvalid, e_rvalid); end
      total++; if (rdata !== e_rdata) begin bad++; $display("FAIL rand_rdata cyc %0d: got %0d want %0d", cyc, rdata, e_rdata); end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (n >= 590) req[i] = 1'b0;
        else if (e_gnt[i]) begin
          if ($urandom_range(0, 2) == 0) new_req(i);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) new_req(i);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0; req_row = '0; req_col = '0; req_we = '0; req_wdata = '0;
`ifdef ARB_STATS_EN
    stat_sel = '0;
`endif
    cyc = 0;
    for (int a = 0; a < 256; a++) shadow[a] = init_val(a);
    ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0;
    do_reset(2);
    test_reset();
    test_stats();
    test_single_read();
    test_render_priority();
    test_round_robin();
    test_out_of_grid();
    test_write_then_read();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
